spi_reg_bank: RTL
=================

// Module: spi_reg_bank
// PURPOSE
//  Register bank directly downstream of the SPI peripheral: consumes its wr_rdn/addr/wdata/we
//  application interface and returns rdata plus the status byte shifted out first in each frame.
//  Holds RW config registers, samples RO status inputs, owns a W1C interrupt-flag/mask pair, a
//  saturating write counter and an ID register. Single clock domain, same clk as the peripheral.
// PARAMETERS
//  REG_W     8     register/data width; addr is REG_W-1 bits
//  NUM_CFG   8     number of RW config registers, addr 0x00..NUM_CFG-1 (legal 1..64)
//  NUM_STS   4     number of RO status inputs, addr 0x40..0x40+NUM_STS-1 (legal 0..60)
//  NUM_EV    4     number of event inputs mapped to IRQ_FLAGS[NUM_EV:1] (legal 0..REG_W-1)
//  ID_VALUE  8'hA5 value returned by ID register
// PORTS
//  clk     in   1              system clock
//  rstb    in   1              reset, synchronous, active-low
//  ena     in   1              global enable; all state holds when 0
//  wr_rdn  in   1              1 = current transaction is write
//  addr    in   REG_W-1        register address
//  wdata   in   REG_W          write data
//  we      in   1              one-cycle write strobe
//  rdata   out  REG_W          registered read data for addr
//  status  out  REG_W          first-byte status to peripheral
//  cfg_o   out  NUM_CFG*REG_W  config regs, reg i at [i*REG_W +: REG_W]
//  sts_i   in   NUM_STS*REG_W  RO status values, same packing
//  ev_i    in   NUM_EV         event pulses, one clk each
//  irq     out  1              registered interrupt, |(IRQ_FLAGS & IRQ_MASK)
// BEHAVIOUR
//  Reset (rstb=0 at posedge clk): cfg regs, IRQ_FLAGS, IRQ_MASK, WR_CNT, rdata, irq all 0;
//   status = 0. Reset overrides ena and any same-cycle we/ev_i.
//  Map: 0x00..NUM_CFG-1 CFG RW; 0x40+i STS RO (sts_i); 0x7C IRQ_FLAGS W1C; 0x7D IRQ_MASK RW;
//   0x7E WR_CNT RO, any write clears; 0x7F ID RO. All other addresses invalid.
//  Write accepted when ena & we & wr_rdn; we with wr_rdn=0 ignored. Update visible next cycle.
//  Writes to STS/ID ignored (valid addr, no error). Invalid-address write or read (read = any cycle
//   with ena, wr_rdn=0 and addr invalid, counted once per addr change) sets IRQ_FLAGS[0].
//  rdata: registered every ena cycle from current addr (1-cycle latency); invalid addr -> 0.
//   Peripheral loads rdata >=1 cycle after addr settles, so latency is within budget.
//  IRQ_FLAGS: bit0 = address error, bits NUM_EV:1 = ev_i, rest read 0. Set on pulse, cleared by
//   writing 1. Same-cycle set and W1C clear of one bit -> set wins (bit stays 1).
//  IRQ_MASK: bits above NUM_EV read 0, not writable.
//  WR_CNT: +1 per accepted write to a valid address other than 0x7E; saturates at 2^REG_W-1;
//   write to 0x7E -> 0 (clear wins, that write not counted). Invalid writes not counted.
//  irq: registered, 1-cycle after flag/mask change.
//  status = {irq, IRQ_FLAGS[0], WR_CNT[REG_W-3:0]}, combinational from registers.
//  ena=0: no register changes, ev_i pulses during ena=0 are lost.
// STRUCTURE
//  Package spi_reg_pkg: address constants (STS_BASE=0x40, ADDR_IRQ_FLAGS=0x7C, ADDR_IRQ_MASK=0x7D,
//   ADDR_WR_CNT=0x7E, ADDR_ID=0x7F), status bit positions (STATUS_IRQ_BIT, STATUS_ERR_BIT).
//  Sub-module spi_irq_ctrl: IRQ_FLAGS/IRQ_MASK regs, W1C/set priority, irq register.
//  Top: address decode, CFG array, WR_CNT, rdata mux/register, status assembly.
// TESTING
//  Reset: rstb=0 2 clk mid-activity -> cfg_o=0, rdata=0, irq=0, status=0x00; read 0x7F -> 0xA5.
//  Write 0x5A to 0x03 (we 1 clk) -> cfg_o[31:24]=0x5A next clk; addr=0x03 -> rdata=0x5A 1 clk
//   later; WR_CNT=1, status=0x01.
//  Write 0x77 to 0x20 -> no cfg change, IRQ_FLAGS=0x01, status[6]=1; mask 0x01 -> irq=1 one clk later.
//  ev_i[0] pulse same clk as write 0x02 to 0x7C -> IRQ_FLAGS[1]=1; second write 0x02 -> 0, irq drops.
//  300 valid cfg writes -> WR_CNT=0xFF (saturated), status[5:0]=0x3F; write 0x7E -> WR_CNT=0.
//  ena=0 with we=1, wr_rdn=1, addr 0x00, wdata 0xFF and ev_i pulse -> no register changes.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared address map, status bit positions and address decode for the SPI register bank.
// No logic of its own; no latency or backpressure.
// Decode is a pure function, evaluated combinationally by its users.
package spi_reg_pkg;

    localparam int unsigned STS_BASE       = 'h40;
    localparam int unsigned ADDR_IRQ_FLAGS = 'h7C;
    localparam int unsigned ADDR_IRQ_MASK  = 'h7D;
    localparam int unsigned ADDR_WR_CNT    = 'h7E;
    localparam int unsigned ADDR_ID        = 'h7F;

    localparam int STATUS_IRQ_BIT = 7;
    localparam int STATUS_ERR_BIT = 6;

    typedef enum logic [2:0] {
        AK_CFG,
        AK_STS,
        AK_FLAGS,
        AK_MASK,
        AK_WRCNT,
        AK_ID,
        AK_INV
    } addr_kind_e;

    function automatic addr_kind_e decode_addr(input int unsigned a,
                                               input int unsigned num_cfg,
                                               input int unsigned num_sts);
        addr_kind_e k;
        k = AK_INV;
        if (a < num_cfg)                                       k = AK_CFG;
        else if ((a >= STS_BASE) && (a < STS_BASE + num_sts))  k = AK_STS;
        else if (a == ADDR_IRQ_FLAGS)                          k = AK_FLAGS;
        else if (a == ADDR_IRQ_MASK)                           k = AK_MASK;
        else if (a == ADDR_WR_CNT)                             k = AK_WRCNT;
        else if (a == ADDR_ID)                                 k = AK_ID;
        return k;
    endfunction

endpackage

// File: rtl/spi_irq_ctrl.sv
// Interrupt flag (W1C) and mask registers plus the registered irq output.
// Flags/mask update on the strobe edge; irq follows the registered flags & mask one edge later.
// No backpressure: every set pulse and clear strobe is absorbed while ena is high.
module spi_irq_ctrl
#(
    parameter int REG_W  = 8,
    parameter int NUM_EV = 4
)(
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic [REG_W-1:0] set_vec,
    input  logic             clr_vld,
    input  logic             mask_wr_vld,
    input  logic [REG_W-1:0] wdata,
    output logic [REG_W-1:0] flags,
    output logic [REG_W-1:0] mask,
    output logic             irq
);

    // Only bit 0 (address error) and the event bits exist.
    localparam logic [REG_W-1:0] IMPL = REG_W'((2 ** (NUM_EV + 1)) - 1);

    logic [REG_W-1:0] clr_vec;

    assign clr_vec = clr_vld ? wdata : '0;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            flags <= '0;
            mask  <= '0;
            irq   <= 1'b0;
        end else if (ena) begin
            // OR-ing the set after the clear makes a coincident set win.
            flags <= ((flags & ~clr_vec) | set_vec) & IMPL;
            if (mask_wr_vld)
                mask <= wdata & IMPL;
            irq <= |(flags & mask);
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI peripheral: config, status, irq, write counter and ID registers.
// rdata is registered one cycle after addr; writes are visible the cycle after the we strobe.
// No backpressure: every strobe is accepted while ena is high; nothing changes while ena is low.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int               REG_W    = 8,
    parameter int               NUM_CFG  = 8,
    parameter int               NUM_STS  = 4,
    parameter int               NUM_EV   = 4,
    parameter logic [REG_W-1:0] ID_VALUE = 8'hA5
)(
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     ena,
    input  logic                     wr_rdn,
    input  logic [REG_W-2:0]         addr,
    input  logic [REG_W-1:0]         wdata,
    input  logic                     we,
    output logic [REG_W-1:0]         rdata,
    output logic [REG_W-1:0]         status,
    output logic [NUM_CFG*REG_W-1:0] cfg_o,
    input  logic [NUM_STS*REG_W-1:0] sts_i,
    input  logic [NUM_EV-1:0]        ev_i,
    output logic                     irq
);

    localparam int AW = REG_W - 1;

    addr_kind_e       kind;
    logic             wr_acc;
    logic             addr_inv;
    logic             rd_err;
    logic             addr_err;
    logic [AW-1:0]    rd_addr_q;
    logic             rd_seen_q;
    logic [REG_W-1:0] cfg_q [NUM_CFG];
    logic [REG_W-1:0] wr_cnt;
    logic [REG_W-1:0] flags;
    logic [REG_W-1:0] mask;
    logic [REG_W-1:0] rd_mux;
    logic [REG_W-1:0] set_vec;

    assign kind     = decode_addr(32'(addr), NUM_CFG, NUM_STS);
    assign wr_acc   = ena & we & wr_rdn;
    assign addr_inv = (kind == AK_INV);
    // A read parked on a bad address flags once, not every cycle it stays there.
    assign rd_err   = ena & ~wr_rdn & addr_inv & (~rd_seen_q | (addr != rd_addr_q));
    assign addr_err = (wr_acc & addr_inv) | rd_err;
    assign set_vec  = REG_W'({ev_i, addr_err});

    spi_irq_ctrl #(
        .REG_W  (REG_W),
        .NUM_EV (NUM_EV)
    ) u_irq_ctrl (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .set_vec     (set_vec),
        .clr_vld     (wr_acc && (kind == AK_FLAGS)),
        .mask_wr_vld (wr_acc && (kind == AK_MASK)),
        .wdata       (wdata),
        .flags       (flags),
        .mask        (mask),
        .irq         (irq)
    );

    always_comb begin
        rd_mux = '0;
        case (kind)
            AK_CFG:
                for (int i = 0; i < NUM_CFG; i++)
                    if (addr == AW'(i)) rd_mux = cfg_q[i];
            AK_STS:
                for (int i = 0; i < NUM_STS; i++)
                    if (addr == AW'(STS_BASE + i)) rd_mux = sts_i[i*REG_W +: REG_W];
            AK_FLAGS: rd_mux = flags;
            AK_MASK:  rd_mux = mask;
            AK_WRCNT: rd_mux = wr_cnt;
            AK_ID:    rd_mux = ID_VALUE;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
            wr_cnt    <= '0;
            rdata     <= '0;
            rd_addr_q <= '0;
            rd_seen_q <= 1'b0;
        end else if (ena) begin
            rdata     <= rd_mux;
            rd_addr_q <= addr;
            rd_seen_q <= 1'b1;
            for (int i = 0; i < NUM_CFG; i++)
                if (wr_acc && (kind == AK_CFG) && (addr == AW'(i))) cfg_q[i] <= wdata;
            if (wr_acc && (kind == AK_WRCNT))
                wr_cnt <= '0;
            else if (wr_acc && !addr_inv && (wr_cnt != '1))
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_o
        assign cfg_o[g*REG_W +: REG_W] = cfg_q[g];
    end

    always_comb begin
        status                 = '0;
        status[REG_W-3:0]      = wr_cnt[REG_W-3:0];
        status[STATUS_ERR_BIT] = flags[0];
        status[STATUS_IRQ_BIT] = irq;
    end

endmodule
